// File: rtl/segre_pkg.sv
// Shared core types and sizes for the segre pipeline, including the
// history file entry layout and its rollback state machine encoding.
package segre_pkg;

  localparam int HF_SIZE   = 8;
  localparam int HF_PTR    = $clog2(HF_SIZE);
  localparam int REG_SIZE  = 5;
  localparam int WORD_SIZE = 32;

  typedef enum logic [1:0] {
    HF_IDLE,
    HF_RECOVER,
    HF_DONE
  } hf_fsm_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 complete;
    logic                 exc;
    logic                 we;
    logic [REG_SIZE-1:0]  dest_reg;
    logic [WORD_SIZE-1:0] old_value;
    logic [WORD_SIZE-1:0] pc;
  } hf_entry_t;

  typedef struct packed {
    logic                 full;
    logic                 empty;
    logic                 retire;
    logic [HF_PTR-1:0]    retire_id;
    logic [HF_PTR-1:0]    alloc_id;
    logic                 recovering;
    logic [WORD_SIZE-1:0] exc_pc;
    logic                 rf_restore_we;
    logic [REG_SIZE-1:0]  rf_restore_waddr;
    logic [WORD_SIZE-1:0] rf_restore_data;
    logic                 recover_done;
  } core_hf_t;

endpackage

// File: rtl/segre_history_file.sv
// In-order history file: allocates at decode, retires completed entries in
// order, and on a MEM exception walks youngest-to-oldest restoring the RF.
module segre_history_file
  import segre_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alloc_i,
  input  logic                 alloc_we_i,
  input  logic [REG_SIZE-1:0]  alloc_dest_reg_i,
  input  logic [WORD_SIZE-1:0] alloc_old_value_i,
  input  logic [WORD_SIZE-1:0] alloc_pc_i,
  output logic [HF_PTR-1:0]    alloc_id_o,
  input  logic                 ex_complete_i,
  input  logic [HF_PTR-1:0]    ex_complete_id_i,
  input  logic                 mem_complete_i,
  input  logic [HF_PTR-1:0]    mem_complete_id_i,
  input  logic                 mem_exc_i,
  input  logic                 rvm_complete_i,
  input  logic [HF_PTR-1:0]    rvm_complete_id_i,
  output logic                 retire_o,
  output logic [HF_PTR-1:0]    retire_id_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 recovering_o,
  output logic                 rf_restore_we_o,
  output logic [REG_SIZE-1:0]  rf_restore_waddr_o,
  output logic [WORD_SIZE-1:0] rf_restore_data_o,
  output logic [WORD_SIZE-1:0] exc_pc_o,
  output logic                 recover_done_o
);

  localparam int                CW      = HF_PTR + 1;
  localparam logic [HF_PTR-1:0] PTR_ONE = HF_PTR'(1);

  hf_entry_t            hf_q [HF_SIZE];
  logic [HF_PTR-1:0]    head_q, tail_q, walk_q;
  logic [CW-1:0]        count_q, count_d;
  hf_fsm_state_e        state_q;
  logic [WORD_SIZE-1:0] exc_pc_q;
  logic                 idle, in_recover, exc_trig, alloc_ok;

  assign idle       = (state_q == HF_IDLE);
  assign in_recover = (state_q == HF_RECOVER);

  assign recovering_o   = !idle;
  assign recover_done_o = (state_q == HF_DONE);
  assign full_o         = (count_q == CW'(HF_SIZE)) | recovering_o;
  assign empty_o        = (count_q == '0);
  assign alloc_id_o     = tail_q;
  assign retire_id_o    = head_q;
  assign exc_pc_o       = exc_pc_q;

  assign retire_o = idle & hf_q[head_q].valid & hf_q[head_q].complete & !hf_q[head_q].exc;
  assign exc_trig = idle & hf_q[head_q].valid & hf_q[head_q].complete &  hf_q[head_q].exc;
  // An excepting cycle swallows any allocation so the walk sees a frozen tail.
  assign alloc_ok = idle & alloc_i & !full_o & !exc_trig;
  assign count_d  = count_q + CW'(alloc_ok) - CW'(retire_o);

  assign rf_restore_we_o    = in_recover & hf_q[walk_q].we;
  assign rf_restore_waddr_o = in_recover ? hf_q[walk_q].dest_reg  : '0;
  assign rf_restore_data_o  = in_recover ? hf_q[walk_q].old_value : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < HF_SIZE; i++) hf_q[i] <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      walk_q   <= '0;
      count_q  <= '0;
      exc_pc_q <= '0;
      state_q  <= HF_IDLE;
    end else begin
      unique case (state_q)
        HF_IDLE: begin
          if (exc_trig) begin
            exc_pc_q <= hf_q[head_q].pc;
            walk_q   <= tail_q - PTR_ONE;
            state_q  <= HF_RECOVER;
          end else begin
            if (ex_complete_i && hf_q[ex_complete_id_i].valid)
              hf_q[ex_complete_id_i].complete <= 1'b1;
            if (mem_complete_i && hf_q[mem_complete_id_i].valid) begin
              hf_q[mem_complete_id_i].complete <= 1'b1;
              hf_q[mem_complete_id_i].exc      <= mem_exc_i;
            end
            if (rvm_complete_i && hf_q[rvm_complete_id_i].valid)
              hf_q[rvm_complete_id_i].complete <= 1'b1;
            if (retire_o) begin
              hf_q[head_q].valid    <= 1'b0;
              hf_q[head_q].complete <= 1'b0;
              head_q                <= head_q + PTR_ONE;
            end
            if (alloc_ok) begin
              hf_q[tail_q] <= '{valid: 1'b1, complete: 1'b0, exc: 1'b0,
                                we: alloc_we_i, dest_reg: alloc_dest_reg_i,
                                old_value: alloc_old_value_i, pc: alloc_pc_i};
              tail_q <= tail_q + PTR_ONE;
            end
            count_q <= count_d;
          end
        end
        HF_RECOVER: begin
          // The head (excepting) entry is restored last, leaving the oldest value.
          if (walk_q == head_q) state_q <= HF_DONE;
          else                  walk_q  <= walk_q - PTR_ONE;
        end
        HF_DONE: begin
          for (int i = 0; i < HF_SIZE; i++) begin
            hf_q[i].valid    <= 1'b0;
            hf_q[i].complete <= 1'b0;
            hf_q[i].exc      <= 1'b0;
          end
          head_q  <= '0;
          tail_q  <= '0;
          count_q <= '0;
          state_q <= HF_IDLE;
        end
        default: state_q <= HF_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_segre_history_file.sv
// Bench for segre_history_file: vector tables, directed rollback sequences and
// a queue-based reference model driven by random traffic.
module tb_segre_history_file;
  import segre_pkg::*;

  // Handshake: alloc_i is only offered while full_o is low; completions are
  // fire-and-forget strobes tagged with an id, with no back-pressure.
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        alloc_i, alloc_we_i;
  logic [4:0]  alloc_dest_reg_i;
  logic [31:0] alloc_old_value_i, alloc_pc_i;
  logic [2:0]  alloc_id_o;
  logic        ex_complete_i, mem_complete_i, mem_exc_i, rvm_complete_i;
  logic [2:0]  ex_complete_id_i, mem_complete_id_i, rvm_complete_id_i;
  logic        retire_o, full_o, empty_o, recovering_o, rf_restore_we_o, recover_done_o;
  logic [2:0]  retire_id_o;
  logic [4:0]  rf_restore_waddr_o;
  logic [31:0] rf_restore_data_o, exc_pc_o;

  segre_history_file dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alloc_i(alloc_i), .alloc_we_i(alloc_we_i), .alloc_dest_reg_i(alloc_dest_reg_i),
    .alloc_old_value_i(alloc_old_value_i), .alloc_pc_i(alloc_pc_i), .alloc_id_o(alloc_id_o),
    .ex_complete_i(ex_complete_i), .ex_complete_id_i(ex_complete_id_i),
    .mem_complete_i(mem_complete_i), .mem_complete_id_i(mem_complete_id_i), .mem_exc_i(mem_exc_i),
    .rvm_complete_i(rvm_complete_i), .rvm_complete_id_i(rvm_complete_id_i),
    .retire_o(retire_o), .retire_id_o(retire_id_o), .full_o(full_o), .empty_o(empty_o),
    .recovering_o(recovering_o), .rf_restore_we_o(rf_restore_we_o),
    .rf_restore_waddr_o(rf_restore_waddr_o), .rf_restore_data_o(rf_restore_data_o),
    .exc_pc_o(exc_pc_o), .recover_done_o(recover_done_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int alloc, we, rd, old;
    int exv, exid, mv, mid, rv, rid;
    int e_ret, e_rid, e_aid, e_full, e_empty;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] old;
    logic [31:0] pc;
    bit          done;
    bit          exc;
  } m_ent_t;

  m_ent_t      m_q[$];
  logic [37:0] exp_q[$];
  vec_t        vt_a[$];
  vec_t        vt_b[$];
  int          m_tail, mode, sz, hd, cid;
  logic [7:0]  used;
  logic [31:0] m_pc;
  logic [37:0] e;
  bit          e_ret, e_exc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clr_in();
    alloc_i = 1'b0; alloc_we_i = 1'b0; alloc_dest_reg_i = '0;
    alloc_old_value_i = '0; alloc_pc_i = '0;
    ex_complete_i = 1'b0; ex_complete_id_i = '0;
    mem_complete_i = 1'b0; mem_complete_id_i = '0; mem_exc_i = 1'b0;
    rvm_complete_i = 1'b0; rvm_complete_id_i = '0;
  endtask

  task automatic tick();
    chk("proto_alloc_while_full", {63'd0, alloc_i & full_o}, 64'd0);
    @(posedge clk_i);
    #1;
    clr_in();
  endtask

  task automatic alloc(input logic we, input logic [4:0] rd, input logic [31:0] old, input logic [31:0] pc);
    alloc_i = 1'b1; alloc_we_i = we; alloc_dest_reg_i = rd;
    alloc_old_value_i = old; alloc_pc_i = pc;
  endtask

  task automatic comp(input int port, input logic [2:0] id, input logic x);
    case (port)
      0: begin ex_complete_i = 1'b1; ex_complete_id_i = id; end
      1: begin mem_complete_i = 1'b1; mem_complete_id_i = id; mem_exc_i = x; end
      default: begin rvm_complete_i = 1'b1; rvm_complete_id_i = id; end
    endcase
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"},
        {47'd0, alloc_id_o, retire_o, retire_id_o, full_o, empty_o, recovering_o,
         rf_restore_we_o, rf_restore_waddr_o, recover_done_o},
        {47'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0});
    chk({tag, "_data"}, {rf_restore_data_o, exc_pc_o}, 64'd0);
  endtask

  task automatic do_reset();
    clr_in();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk_reset_vals("in_reset");
    rst_i = 1'b0;
    #1;
  endtask

  task automatic apply_vecs(input string tag, input vec_t vq[$]);
    do_reset();
    foreach (vq[k]) begin
      alloc_i = 1'(vq[k].alloc); alloc_we_i = 1'(vq[k].we); alloc_dest_reg_i = 5'(vq[k].rd);
      alloc_old_value_i = 32'(vq[k].old); alloc_pc_i = 32'(vq[k].old);
      ex_complete_i = 1'(vq[k].exv); ex_complete_id_i = 3'(vq[k].exid);
      mem_complete_i = 1'(vq[k].mv); mem_complete_id_i = 3'(vq[k].mid);
      rvm_complete_i = 1'(vq[k].rv); rvm_complete_id_i = 3'(vq[k].rid);
      #1;
      chk($sformatf("%s[%0d]_retire", tag, k), {63'd0, retire_o}, 64'(vq[k].e_ret));
      if (vq[k].e_ret != 0)
        chk($sformatf("%s[%0d]_retire_id", tag, k), {61'd0, retire_id_o}, 64'(vq[k].e_rid));
      chk($sformatf("%s[%0d]_alloc_id", tag, k), {61'd0, alloc_id_o}, 64'(vq[k].e_aid));
      chk($sformatf("%s[%0d]_full", tag, k), {63'd0, full_o}, 64'(vq[k].e_full));
      chk($sformatf("%s[%0d]_empty", tag, k), {63'd0, empty_o}, 64'(vq[k].e_empty));
      tick();
    end
  endtask

  // Consumes exp_q one restore per cycle, then checks the done pulse and flush.
  task automatic check_walk(input string tag, input logic [31:0] pc);
    logic [37:0] w;
    int k;
    k = 0;
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      #1;
      chk($sformatf("%s_w%0d_state", tag, k), {60'd0, recovering_o, full_o, retire_o, recover_done_o}, {60'd0, 4'b1100});
      chk($sformatf("%s_w%0d_exc_pc", tag, k), {32'd0, exc_pc_o}, {32'd0, pc});
      chk($sformatf("%s_w%0d_we", tag, k), {63'd0, rf_restore_we_o}, {63'd0, w[37]});
      if (w[37])
        chk($sformatf("%s_w%0d_addr_data", tag, k), {27'd0, rf_restore_waddr_o, rf_restore_data_o}, {27'd0, w[36:0]});
      tick();
      k++;
    end
    #1;
    chk({tag, "_done_pulse"}, {61'd0, recover_done_o, recovering_o, rf_restore_we_o}, {61'd0, 3'b110});
    tick();
    #1;
    chk({tag, "_after_flags"}, {60'd0, recover_done_o, recovering_o, empty_o, full_o}, {60'd0, 4'b0010});
    chk({tag, "_after_alloc_id"}, {61'd0, alloc_id_o}, 64'd0);
    chk({tag, "_after_exc_pc"}, {32'd0, exc_pc_o}, {32'd0, pc});
  endtask

  function automatic void mark(input int id, input bit is_mem, input bit x);
    int idx;
    idx = (id - hd) & 7;
    if (idx < sz) begin
      m_q[idx].done = 1'b1;
      if (is_mem) m_q[idx].exc = x;
    end
  endfunction

  initial begin
    clr_in();
    // alloc we rd old | exv exid mv mid rv rid | e_ret e_rid e_aid e_full e_empty
    vt_a = '{
      '{1,1,1,'h11, 0,0,0,0,0,0, 0,0,0,0,1},
      '{1,1,2,'h22, 0,0,0,0,0,0, 0,0,1,0,0},
      '{1,1,3,'h33, 0,0,0,0,0,0, 0,0,2,0,0},
      '{0,0,0,0,    1,2,1,0,1,1, 0,0,3,0,0},
      '{0,0,0,0,    0,0,0,0,0,0, 1,0,3,0,0},
      '{0,0,0,0,    0,0,0,0,0,0, 1,1,3,0,0},
      '{0,0,0,0,    0,0,0,0,0,0, 1,2,3,0,0},
      '{0,0,0,0,    1,3,0,0,0,0, 0,0,3,0,1},
      '{1,1,4,'h44, 0,0,0,0,0,0, 0,0,3,0,1},
      '{0,0,0,0,    0,0,0,0,0,0, 0,0,4,0,0}
    };
    vt_b = '{
      '{1,1,1,'h10, 0,0,0,0,0,0, 0,0,0,0,1},
      '{1,1,2,'h20, 0,0,0,0,0,0, 0,0,1,0,0},
      '{1,1,3,'h30, 1,0,0,0,0,0, 0,0,2,0,0},
      '{1,1,4,'h40, 1,1,1,2,0,0, 1,0,3,0,0},
      '{0,0,0,0,    0,0,0,0,1,3, 1,1,4,0,0},
      '{0,0,0,0,    0,0,0,0,0,0, 1,2,4,0,0},
      '{0,0,0,0,    0,0,0,0,0,0, 1,3,4,0,0},
      '{0,0,0,0,    0,0,0,0,0,0, 0,0,4,0,1}
    };
    apply_vecs("basic", vt_a);
    apply_vecs("simul", vt_b);

    // Full and wrap: eight allocations, two retires, two reallocations.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc(1'b1, 5'(i + 1), 32'(i), 32'(4 * i));
      #1;
      chk($sformatf("wrap_alloc_id%0d", i), {61'd0, alloc_id_o}, 64'(i));
      chk($sformatf("wrap_notfull%0d", i), {63'd0, full_o}, 64'd0);
      tick();
    end
    comp(0, 3'd0, 1'b0); comp(2, 3'd1, 1'b0);
    #1;
    chk("wrap_full_at_8", {62'd0, full_o, empty_o}, {62'd0, 2'b10});
    tick();
    #1;
    chk("wrap_retire0", {60'd0, retire_o, retire_id_o}, {60'd0, 1'b1, 3'd0});
    chk("wrap_full_no_bypass", {63'd0, full_o}, 64'd1);
    tick();
    alloc(1'b1, 5'd20, 32'h80, 32'h80);
    #1;
    chk("wrap_retire1", {60'd0, retire_o, retire_id_o}, {60'd0, 1'b1, 3'd1});
    chk("wrap_realloc0", {61'd0, alloc_id_o}, 64'd0);
    tick();
    alloc(1'b1, 5'd21, 32'h84, 32'h84);
    #1;
    chk("wrap_realloc1", {61'd0, alloc_id_o}, 64'd1);
    tick();
    #1;
    chk("wrap_full_again", {63'd0, full_o}, 64'd1);
    chk("wrap_next_id", {61'd0, alloc_id_o}, 64'd2);

    // Exception rollback with a dropped allocation and completion.
    do_reset();
    alloc(1'b1, 5'd5, 32'hA, 32'h100); tick();
    alloc(1'b1, 5'd6, 32'hB, 32'h104); tick();
    alloc(1'b1, 5'd5, 32'hC, 32'h108); tick();
    alloc(1'b0, 5'd7, 32'hD, 32'h10C); tick();
    comp(1, 3'd0, 1'b1); comp(0, 3'd1, 1'b0);
    #1;
    chk("exc_pre_no_retire", {63'd0, retire_o}, 64'd0);
    tick();
    alloc(1'b1, 5'd9, 32'hEE, 32'h200); comp(0, 3'd2, 1'b0);
    #1;
    chk("exc_trigger_no_retire", {62'd0, retire_o, recovering_o}, 64'd0);
    tick();
    exp_q = '{{1'b0, 5'd7, 32'hD}, {1'b1, 5'd5, 32'hC}, {1'b1, 5'd6, 32'hB}, {1'b1, 5'd5, 32'hA}};
    check_walk("exc", 32'h100);

    // Wrapped rollback: head 6, tail 1.
    do_reset();
    for (int i = 0; i < 6; i++) begin alloc(1'b0, 5'd0, 32'd0, 32'(i)); tick(); end
    comp(0, 3'd0, 1'b0); comp(1, 3'd1, 1'b0); comp(2, 3'd2, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin comp(0, 3'd3, 1'b0); comp(1, 3'd4, 1'b0); comp(2, 3'd5, 1'b0); end
      #1;
      chk($sformatf("wrapexc_retire%0d", i), {60'd0, retire_o, retire_id_o}, {60'd0, 1'b1, 3'(i)});
      tick();
    end
    #1;
    chk("wrapexc_empty_tail6", {60'd0, empty_o, alloc_id_o}, {60'd0, 1'b1, 3'd6});
    alloc(1'b1, 5'd10, 32'h60, 32'h600); tick();
    alloc(1'b1, 5'd11, 32'h70, 32'h700); tick();
    alloc(1'b1, 5'd12, 32'h80, 32'h800); tick();
    comp(1, 3'd6, 1'b1); comp(0, 3'd7, 1'b0); tick();
    #1;
    chk("wrapexc_trigger", {62'd0, retire_o, recovering_o}, 64'd0);
    tick();
    exp_q = '{{1'b1, 5'd12, 32'h80}, {1'b1, 5'd11, 32'h70}, {1'b1, 5'd10, 32'h60}};
    check_walk("wrapexc", 32'h600);

    // Reset during the second restore cycle.
    do_reset();
    alloc(1'b1, 5'd3, 32'h31, 32'h300); tick();
    alloc(1'b1, 5'd4, 32'h41, 32'h304); tick();
    alloc(1'b1, 5'd5, 32'h51, 32'h308); tick();
    comp(1, 3'd0, 1'b1); tick();
    tick();
    #1;
    chk("rstmid_w0", {57'd0, rf_restore_we_o, rf_restore_waddr_o, recovering_o}, {57'd0, 1'b1, 5'd5, 1'b1});
    tick();
    #1;
    chk("rstmid_w1", {57'd0, rf_restore_we_o, rf_restore_waddr_o, recovering_o}, {57'd0, 1'b1, 5'd4, 1'b1});
    rst_i = 1'b1;
    #1;
    chk_reset_vals("rstmid_immediate");
    tick();
    #1;
    chk_reset_vals("rstmid_held");
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk_reset_vals($sformatf("rstmid_after%0d", i));
    end

    // Random traffic against the queue model.
    do_reset();
    m_q.delete(); exp_q.delete(); m_tail = 0; m_pc = '0; mode = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      sz = m_q.size();
      hd = (m_tail - sz) & 7;
      used = '0;
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          cid = (sz > 0) ? ((hd + int'($urandom_range(0, sz))) & 7) : int'($urandom_range(0, 7));
          if (!used[cid]) begin
            used[cid] = 1'b1;
            comp(p, 3'(cid), ($urandom_range(0, 15) == 0));
          end
        end
      end
      if (mode == 0) begin
        if (sz < 8 && $urandom_range(0, 1) == 1)
          alloc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom);
        e_ret = (sz > 0) && m_q[0].done && !m_q[0].exc;
        e_exc = (sz > 0) && m_q[0].done && m_q[0].exc;
        #1;
        chk($sformatf("rnd%0d_retire", cyc), {63'd0, retire_o}, {63'd0, e_ret});
        if (e_ret) chk($sformatf("rnd%0d_retire_id", cyc), {61'd0, retire_id_o}, 64'(hd));
        chk($sformatf("rnd%0d_flags", cyc), {59'd0, full_o, empty_o, recovering_o, recover_done_o, rf_restore_we_o},
            {59'd0, (sz == 8), (sz == 0), 3'b000});
        chk($sformatf("rnd%0d_alloc_id", cyc), {61'd0, alloc_id_o}, 64'(m_tail));
        chk($sformatf("rnd%0d_exc_pc", cyc), {32'd0, exc_pc_o}, {32'd0, m_pc});
        if (e_exc) begin
          for (int i = sz - 1; i >= 0; i--) exp_q.push_back({m_q[i].we, m_q[i].rd, m_q[i].old});
          m_pc = m_q[0].pc;
          mode = 1;
        end else begin
          if (ex_complete_i)  mark(int'(ex_complete_id_i), 1'b0, 1'b0);
          if (mem_complete_i) mark(int'(mem_complete_id_i), 1'b1, mem_exc_i);
          if (rvm_complete_i) mark(int'(rvm_complete_id_i), 1'b0, 1'b0);
          if (e_ret) void'(m_q.pop_front());
          if (alloc_i) begin
            m_q.push_back('{alloc_we_i, alloc_dest_reg_i, alloc_old_value_i, alloc_pc_i, 1'b0, 1'b0});
            m_tail = (m_tail + 1) & 7;
          end
        end
      end else if (mode == 1) begin
        e = exp_q.pop_front();
        #1;
        chk($sformatf("rnd%0d_rec_flags", cyc), {61'd0, recovering_o, full_o, retire_o}, {61'd0, 3'b110});
        chk($sformatf("rnd%0d_rec_we", cyc), {63'd0, rf_restore_we_o}, {63'd0, e[37]});
        if (e[37])
          chk($sformatf("rnd%0d_rec_data", cyc), {27'd0, rf_restore_waddr_o, rf_restore_data_o}, {27'd0, e[36:0]});
        chk($sformatf("rnd%0d_rec_pc", cyc), {32'd0, exc_pc_o}, {32'd0, m_pc});
        if (exp_q.size() == 0) mode = 2;
      end else begin
        #1;
        chk($sformatf("rnd%0d_done", cyc), {61'd0, recover_done_o, recovering_o, rf_restore_we_o}, {61'd0, 3'b110});
        m_q.delete();
        m_tail = 0;
        mode = 0;
      end
      tick();
    end

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
